// File: rtl/sram_arbiter_if.sv
// Requester-side handshakes of the SRAM arbiter: the video read port and the CPU read/write port.
// master = requesters (core/testbench), slave = arbiter.
interface sram_arbiter_if #(
    parameter int AW = 21
);
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;
    logic [7:0]    vid_rdata;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata;
    logic          cpu_ack;
    logic [7:0]    cpu_rdata;

    modport master (
        output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  vid_ack, vid_rdata, cpu_ack, cpu_rdata
    );

    modport slave (
        input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output vid_ack, vid_rdata, cpu_ack, cpu_rdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one async 8-bit SRAM between video (read) and CPU (read/write); SRAM_ARB_ROUND_ROBIN_EN selects round-robin over fixed video priority.
// Latency req->ack: read ACCESS_CYCLES+1, write ACCESS_CYCLES+2 edges; one-cycle turnaround before the next grant.
// Backpressure: requests are held until their one-cycle ack; the losing requester simply waits for a later IDLE.
module sram_arbiter #(
    parameter int AW            = 21,
    parameter int ACCESS_CYCLES = 3
) (
    input  logic          clk_chipset,
    input  logic          reset_n,
    sram_arbiter_if.slave bus,
    output logic [AW-1:0] SRAM_ADDR,
    inout  wire  [7:0]    SRAM_DATA,
    output logic          SRAM_WE_n
);
    localparam int            CW       = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(ACCESS_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, TURN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    vid_rdata_q, vid_rdata_d;
    logic [7:0]    cpu_rdata_q, cpu_rdata_d;
    logic          we_n_q, we_n_d;
    logic          oe_q, oe_d;
    logic          sel_vid_q, sel_vid_d;
    logic          vid_ack_q, vid_ack_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          gnt_vid, gnt_cpu;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic last_vid_q, last_vid_d;

    // On a tie the port that did not win last time goes first.
    assign gnt_vid = (state_q == IDLE) && bus.vid_req && (!bus.cpu_req || !last_vid_q);

    always_comb begin
        last_vid_d = last_vid_q;
        if (gnt_vid) begin
            last_vid_d = 1'b1;
        end else if (gnt_cpu) begin
            last_vid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_chipset or negedge reset_n) begin
        if (!reset_n) begin
            last_vid_q <= 1'b0;
        end else begin
            last_vid_q <= last_vid_d;
        end
    end
`else
    assign gnt_vid = (state_q == IDLE) && bus.vid_req;
`endif
    assign gnt_cpu = (state_q == IDLE) && bus.cpu_req && !gnt_vid;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        vid_rdata_d = vid_rdata_q;
        cpu_rdata_d = cpu_rdata_q;
        we_n_d      = 1'b1;
        oe_d        = oe_q;
        sel_vid_d   = sel_vid_q;
        vid_ack_d   = 1'b0;
        cpu_ack_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt_vid) begin
                    addr_d    = bus.vid_addr;
                    sel_vid_d = 1'b1;
                    cnt_d     = CNT_LOAD;
                    state_d   = RD;
                end else if (gnt_cpu) begin
                    addr_d    = bus.cpu_addr;
                    sel_vid_d = 1'b0;
                    cnt_d     = CNT_LOAD;
                    if (bus.cpu_we) begin
                        wdata_d = bus.cpu_wdata;
                        oe_d    = 1'b1;
                        state_d = WR_SETUP;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (cnt_q == '0) begin
                    if (sel_vid_q) begin
                        vid_rdata_d = SRAM_DATA;
                        vid_ack_d   = 1'b1;
                    end else begin
                        cpu_rdata_d = SRAM_DATA;
                        cpu_ack_d   = 1'b1;
                    end
                    state_d = TURN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WR_SETUP: begin
                we_n_d  = 1'b0;
                cnt_d   = CNT_LOAD;
                state_d = WR_PULSE;
            end
            WR_PULSE: begin
                if (cnt_q == '0) begin
                    cpu_ack_d = 1'b1;
                    state_d   = TURN;
                end else begin
                    we_n_d = 1'b0;
                    cnt_d  = cnt_q - CW'(1);
                end
            end
            TURN: begin
                // Write data was held through this cycle for SRAM hold time.
                oe_d    = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_chipset or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            vid_rdata_q <= '0;
            cpu_rdata_q <= '0;
            we_n_q      <= 1'b1;
            oe_q        <= 1'b0;
            sel_vid_q   <= 1'b0;
            vid_ack_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            vid_rdata_q <= vid_rdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            we_n_q      <= we_n_d;
            oe_q        <= oe_d;
            sel_vid_q   <= sel_vid_d;
            vid_ack_q   <= vid_ack_d;
            cpu_ack_q   <= cpu_ack_d;
        end
    end

    assign SRAM_ADDR     = addr_q;
    assign SRAM_WE_n     = we_n_q;
    assign SRAM_DATA     = oe_q ? wdata_q : 8'hzz;
    assign bus.vid_ack   = vid_ack_q;
    assign bus.vid_rdata = vid_rdata_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural async SRAM on the pins.
module tb_sram_arbiter;
    localparam int AW = 21;
    localparam int AC = 3;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #10 clk = ~clk;

    sram_arbiter_if #(.AW(AW)) bus ();

    logic [AW-1:0] sram_addr;
    wire  [7:0]    sram_data;
    logic          sram_we_n;

    sram_arbiter #(.AW(AW), .ACCESS_CYCLES(AC)) dut (
        .clk_chipset (clk),
        .reset_n     (reset_n),
        .bus         (bus.slave),
        .SRAM_ADDR   (sram_addr),
        .SRAM_DATA   (sram_data),
        .SRAM_WE_n   (sram_we_n)
    );

    // SRAM model: drives only when enabled and WE_n high; mdl_fix forces a marker byte.
    logic [7:0] mem [0:(1<<AW)-1];
    logic       mdl_oe  = 1'b0;
    logic       mdl_fix = 1'b0;
    assign sram_data = (mdl_oe && sram_we_n) ? (mdl_fix ? 8'h3C : mem[sram_addr]) : 8'hzz;
    always @(posedge sram_we_n) if (reset_n) mem[sram_addr] <= sram_data;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    logic          run_mon = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    always @(negedge clk) begin
        if (run_mon) begin
            check("ack_exclusive", {31'd0, bus.vid_ack & bus.cpu_ack}, 32'd0);
            if (!sram_we_n) check("addr_stable_we_low", {11'd0, sram_addr}, {11'd0, prev_addr});
        end
        prev_addr = sram_addr;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    wdata;
        logic [7:0]    exp;
        int            exp_lat;
    } vec_t;
    vec_t vecs [8];

    task automatic cpu_xact(input logic we, input logic [AW-1:0] a, input logic [7:0] wd,
                            input logic [7:0] exp_bus, output int lat, output logic bus_ok);
        @(negedge clk);
        mdl_oe        = !we;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = wd;
        lat    = 0;
        bus_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (sram_data !== exp_bus) bus_ok = 1'b0;
        end while (!bus.cpu_ack && lat < 50);
        bus.cpu_req = 1'b0;
    endtask

    initial begin
        int   lat;
        logic ok;
        bus.vid_req   = 1'b0;
        bus.vid_addr  = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;

        vecs[0] = '{1'b0, 21'h00123,  8'h00, 8'hA5, AC + 1};
        vecs[1] = '{1'b1, 21'h1FFFFF, 8'h3C, 8'h00, AC + 2};
        vecs[2] = '{1'b0, 21'h00077,  8'h00, 8'h5A, AC + 1};
        vecs[3] = '{1'b0, 21'h1FFFFF, 8'h00, 8'h3C, AC + 1};
        vecs[4] = '{1'b1, 21'h00000,  8'hFF, 8'h00, AC + 2};
        vecs[5] = '{1'b0, 21'h00000,  8'h00, 8'hFF, AC + 1};
        vecs[6] = '{1'b1, 21'h00124,  8'h00, 8'h00, AC + 2};
        vecs[7] = '{1'b0, 21'h00124,  8'h00, 8'h00, AC + 1};

        // Reset values, with the model driving a marker to show the DUT is off the bus.
        mdl_oe  = 1'b1;
        mdl_fix = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_we_n",      {31'd0, sram_we_n}, 32'd1);
        check("rst_addr",      {11'd0, sram_addr}, 32'd0);
        check("rst_bus_hiz",   {24'd0, sram_data}, 32'h3C);
        check("rst_vid_ack",   {31'd0, bus.vid_ack}, 32'd0);
        check("rst_cpu_ack",   {31'd0, bus.cpu_ack}, 32'd0);
        check("rst_vid_rdata", {24'd0, bus.vid_rdata}, 32'd0);
        check("rst_cpu_rdata", {24'd0, bus.cpu_rdata}, 32'd0);
        reset_n = 1'b1;
        mdl_fix = 1'b0;
        mdl_oe  = 1'b0;
        mem[21'h00077] = 8'h5A;
        run_mon = 1'b1;

        // First write: detailed pin waveform.
        begin
            int we_low = 0, first_low = 0, last_low = 0, ack_cyc = 0;
            logic addr_ok = 1'b1, dat_ok = 1'b1;
            @(negedge clk);
            bus.cpu_req   = 1'b1;
            bus.cpu_we    = 1'b1;
            bus.cpu_addr  = 21'h00123;
            bus.cpu_wdata = 8'hA5;
            for (int c = 1; c <= 7; c++) begin
                @(negedge clk);
                if (!sram_we_n) begin
                    we_low++;
                    if (first_low == 0) first_low = c;
                    last_low = c;
                end
                if (c <= AC + 2) begin
                    if (sram_addr !== 21'h00123) addr_ok = 1'b0;
                    if (sram_data !== 8'hA5) dat_ok = 1'b0;
                end
                if (bus.cpu_ack && ack_cyc == 0) begin
                    ack_cyc = c;
                    bus.cpu_req = 1'b0;
                end
            end
            check("wr_we_low_cycles", we_low, AC);
            check("wr_we_first_low", first_low, 2);
            check("wr_we_last_low", last_low, AC + 1);
            check("wr_ack_latency", ack_cyc, AC + 2);
            check("wr_addr_stable", {31'd0, addr_ok}, 32'd1);
            check("wr_data_through_turn", {31'd0, dat_ok}, 32'd1);
            check("wr_mem_written", {24'd0, mem[21'h00123]}, 32'hA5);
        end

        // CPU transaction table.
        for (int i = 0; i < 8; i++) begin
            cpu_xact(vecs[i].we, vecs[i].addr, vecs[i].wdata,
                     vecs[i].we ? vecs[i].wdata : vecs[i].exp, lat, ok);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_bus", i), {31'd0, ok}, 32'd1);
            if (vecs[i].we) check($sformatf("vec%0d_mem", i), {24'd0, mem[vecs[i].addr]}, {24'd0, vecs[i].wdata});
            else            check($sformatf("vec%0d_rdata", i), {24'd0, bus.cpu_rdata}, {24'd0, vecs[i].exp});
        end

        // Simultaneous requests: video first, CPU on the next IDLE.
        begin
            int vc = 0, cc = 0;
            mem[21'h10] = 8'h11;
            mem[21'h20] = 8'h22;
            @(negedge clk);
            mdl_oe       = 1'b1;
            bus.vid_addr = 21'h10;
            bus.vid_req  = 1'b1;
            bus.cpu_we   = 1'b0;
            bus.cpu_addr = 21'h20;
            bus.cpu_req  = 1'b1;
            for (int c = 1; c <= 30; c++) begin
                @(negedge clk);
                if (bus.vid_ack && vc == 0) begin vc = c; bus.vid_req = 1'b0; end
                if (bus.cpu_ack && cc == 0) begin cc = c; bus.cpu_req = 1'b0; end
            end
            check("sim_vid_ack_cycle", vc, AC + 1);
            check("sim_cpu_ack_cycle", cc, 2 * AC + 3);
            check("sim_vid_rdata", {24'd0, bus.vid_rdata}, 32'h11);
            check("sim_cpu_rdata", {24'd0, bus.cpu_rdata}, 32'h22);
        end

        // Continuous video with CPU pending.
        begin
            int   nv = 0, nc = 0, k = 0;
            logic seq [0:31];
            mem[21'h30] = 8'h33;
            mem[21'h40] = 8'h44;
            @(negedge clk);
            bus.vid_addr = 21'h30;
            bus.vid_req  = 1'b1;
            bus.cpu_addr = 21'h40;
            bus.cpu_we   = 1'b0;
            bus.cpu_req  = 1'b1;
            for (int c = 1; c <= 100; c++) begin
                @(negedge clk);
                if (bus.vid_ack) begin nv++; seq[k] = 1'b1; k++; end
                if (bus.cpu_ack) begin nc++; seq[k] = 1'b0; k++; end
            end
            bus.vid_req = 1'b0;
            bus.cpu_req = 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            check("rr_grant0_vid", {31'd0, seq[0]}, 32'd1);
            check("rr_grant1_cpu", {31'd0, seq[1]}, 32'd0);
            check("rr_grant2_vid", {31'd0, seq[2]}, 32'd1);
            check("rr_grant3_cpu", {31'd0, seq[3]}, 32'd0);
            check("rr_vid_acks", nv, 10);
            check("rr_cpu_acks", nc, 10);
`else
            check("starve_cpu_acks", nc, 0);
            check("starve_vid_acks", nv, 20);
            check("starve_first_vid", {31'd0, seq[0]}, 32'd1);
`endif
            repeat (12) @(negedge clk);
        end

        // Back-to-back video reads, address 0..7.
        begin
            int n = 0, last = 0;
            logic [7:0] e;
            for (int i = 0; i < 8; i++) mem[i] = 8'h80 + 8'(i * 3);
            @(negedge clk);
            mdl_oe       = 1'b1;
            bus.vid_addr = '0;
            bus.vid_req  = 1'b1;
            for (int c = 1; c <= 60 && n < 8; c++) begin
                @(negedge clk);
                if (bus.vid_ack) begin
                    e = 8'h80 + 8'(n * 3);
                    check($sformatf("b2b%0d_rdata", n), {24'd0, bus.vid_rdata}, {24'd0, e});
                    check($sformatf("b2b%0d_gap", n), c - last, (n == 0) ? AC + 1 : AC + 2);
                    last = c;
                    n++;
                    if (n == 8) bus.vid_req = 1'b0;
                    else        bus.vid_addr = AW'(n);
                end
            end
            check("b2b_ack_count", n, 8);
            repeat (3) @(negedge clk);
        end

        // Reset during the second WE_n-low cycle of a write.
        begin
            int ack_seen = 0;
            @(negedge clk);
            mdl_oe        = 1'b0;
            bus.cpu_req   = 1'b1;
            bus.cpu_we    = 1'b1;
            bus.cpu_addr  = 21'h00200;
            bus.cpu_wdata = 8'hC3;
            repeat (3) @(negedge clk);
            check("mid_we_low_before_rst", {31'd0, sram_we_n}, 32'd0);
            reset_n = 1'b0;
            mdl_fix = 1'b1;
            mdl_oe  = 1'b1;
            #1;
            check("mid_rst_we_n_async", {31'd0, sram_we_n}, 32'd1);
            check("mid_rst_bus_hiz", {24'd0, sram_data}, 32'h3C);
            bus.cpu_req = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (bus.cpu_ack) ack_seen++;
            end
            reset_n = 1'b1;
            repeat (4) begin
                @(negedge clk);
                if (bus.cpu_ack) ack_seen++;
            end
            check("mid_rst_no_ack", ack_seen, 0);
            check("post_rst_addr", {11'd0, sram_addr}, 32'd0);
            check("post_rst_we_n", {31'd0, sram_we_n}, 32'd1);
            check("post_rst_bus_hiz", {24'd0, sram_data}, 32'h3C);
            check("post_rst_cpu_rdata", {24'd0, bus.cpu_rdata}, 32'd0);
            check("post_rst_vid_rdata", {24'd0, bus.vid_rdata}, 32'd0);
            mdl_fix = 1'b0;
            cpu_xact(1'b0, 21'h00123, 8'h00, 8'hA5, lat, ok);
            check("post_rst_read_latency", lat, AC + 1);
            check("post_rst_read_rdata", {24'd0, bus.cpu_rdata}, 32'hA5);
        end

        repeat (2) @(negedge clk);
        run_mon = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single 8-bit asynchronous board SRAM between two requesters: the video fetch port (read-only) and the CPU/chipset port (read/write).
- Sequences the SRAM timing: address setup, WE_n pulse width, data capture and bus turnaround.
- Sits between the system core and the top-level SRAM pins, in the chipset clock domain.

Parameters:
- AW, 21, address width; matches the system SRAM_ADDR bus. The top level truncates it to the 19 physical pins.
- ACCESS_CYCLES, 3, clock cycles of the read access or WE_n-low window. Must be at least 1. 3 cycles at 50 MHz covers a 55 ns part.

Ports:
- clk_chipset  in  1  system clock (50 MHz)
- reset_n  in  1  asynchronous, active-low reset
- vid_req  in  1  video read request; held until vid_ack
- vid_addr  in  AW  video byte address; stable while vid_req is high
- vid_ack  out  1  one-cycle pulse; vid_rdata is valid from this cycle on
- vid_rdata  out  8  video read data; holds until the next vid_ack
- cpu_req  in  1  CPU request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_addr  in  AW  CPU byte address
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  8  CPU read data; holds until the next CPU read ack
- SRAM_ADDR  out  AW  registered SRAM address
- SRAM_DATA  inout  8  SRAM data bus; tristated except during writes
- SRAM_WE_n  out  1  SRAM write enable, active low, registered

Behaviour:
- Clock and reset: one clock, clk_chipset. reset_n is asynchronous and active-low.
- Reset values: state IDLE, SRAM_WE_n=1, SRAM_DATA hi-Z, SRAM_ADDR=0, vid_ack=cpu_ack=0, vid_rdata=cpu_rdata=0, last-grant = CPU.
- States: IDLE, RD, WR_SETUP, WR_PULSE, TURN. A down-counter cnt is loaded with ACCESS_CYCLES-1.
- IDLE:
  - Samples the requests. Fixed priority: video wins over CPU (see Optional Feature).
  - Grant latches SRAM_ADDR at the same edge.
  - Video grant, or CPU grant with cpu_we=0 -> RD.
  - CPU grant with cpu_we=1 -> WR_SETUP.
  - No request: stays in IDLE, outputs idle.
- RD:
  - WE_n=1, bus hi-Z, held for ACCESS_CYCLES cycles.
  - On the final edge, SRAM_DATA is captured into the granted port's rdata and that port's ack is set -> TURN.
- WR_SETUP:
  - One cycle: address and cpu_wdata driven, WE_n=1 -> WR_PULSE.
- WR_PULSE:
  - WE_n=0 and data driven for ACCESS_CYCLES cycles.
  - On exit, WE_n=1 and cpu_ack is set -> TURN.
- TURN:
  - One cycle, ack high. WE_n=1. Address held.
  - After a write, data is still driven during TURN for hold time and released on exit.
  - -> IDLE.
  - The requester may drop req during the ack cycle. If req is still high in IDLE, it is a new back-to-back request.
- Latency, req high in IDLE to ack:
  - Read: ACCESS_CYCLES+1 edges.
  - Write: ACCESS_CYCLES+2 edges.
  - Minimum repeat period: read ACCESS_CYCLES+2 cycles, write ACCESS_CYCLES+3 cycles.
- Write strobe integrity: WE_n is never low while SRAM_ADDR changes. Address changes only on the IDLE grant edge.
- Simultaneous requests: exactly one grant. The loser's req stays pending and is served on the next IDLE.
- Request dropped before ack: protocol violation. The arbiter completes the access anyway and pulses ack.
- Reset mid-operation:
  - WE_n goes high and the bus goes hi-Z immediately (asynchronous).
  - The access is aborted and no ack is issued. SRAM contents at that address are undefined.
- Acks are mutually exclusive. vid_ack and cpu_ack are never high in the same cycle.

Optional Feature:
- Macro: SRAM_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests, the port not granted last wins. last-grant updates on every grant. This prevents CPU starvation under continuous video traffic.
- Undefined: fixed video priority. last-grant logic is absent, and the CPU waits while vid_req is continuously high.

Test Plan:
- Reset, then CPU write addr 0x00123, data 0xA5: SRAM_WE_n low for exactly 3 cycles, address stable from 1 cycle before WE_n falls to 1 cycle after it rises, data driven through TURN. cpu_ack arrives 5 edges after req.
- CPU read 0x00123 from the SRAM model: cpu_rdata=0xA5, cpu_ack 4 edges after req, SRAM_DATA hi-Z throughout.
- vid_req and cpu_req asserted in the same cycle, macro undefined: video is served first, then CPU. Acks are ordered and never overlap.
- Continuous vid_req with cpu_req held: macro undefined -> no cpu_ack within 100 cycles. Macro defined -> grants alternate V, C, V, C.
- Assert reset_n=0 in the second WR_PULSE cycle: WE_n=1 and the bus goes hi-Z before the next edge, no cpu_ack. After release the state is IDLE with all outputs at reset values.
- Back-to-back video reads with vid_req held and the address incrementing 0..7: 8 acks, one every 5 cycles, with vid_rdata matching the model.
